// File: rtl/core_launcher.sv
// core_launcher
//   Host-side initiator for the core's start/done handshake. Streams machine
//   words into instruction memory, pulses start to the core, waits for done
//   and reports run length and outcome.
//
// Optional feature macro: CORE_LAUNCHER_WATCHDOG_EN
//   Defined   : RUN ends with o_timeout=1 once o_cycle_count reaches
//               TIMEOUT_CYCLES without core_done.
//   Undefined : RUN waits indefinitely, o_timeout is always 0.
//
// Handshake: a load word transfers on a rising clock edge where
//   i_load_valid && o_load_ready are both high. The source must hold
//   i_load_data/i_load_last stable while i_load_valid=1 and o_load_ready=0.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_load_valid/o_load_ready/i_load_data/i_load_last  program load stream
//   i_launch              request a run of the loaded program
//   o_imem_wen/o_imem_waddr/o_imem_wdata  instruction-memory write port
//   o_start               one-cycle start pulse to the core
//   i_core_done           core's done output
//   o_busy                high in every state except IDLE
//   o_finished/o_timeout  run outcome flags
//   o_cycle_count         cycles spent in RUN (saturating)
//   o_instr_count         number of words loaded
//   o_state               debug view of the FSM state
module core_launcher #(
  parameter int ADDR_W         = 8,
  parameter int INSTR_W        = 9,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_valid,
  output logic               o_load_ready,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_load_last,
  input  logic               i_launch,
  output logic               o_imem_wen,
  output logic [ADDR_W-1:0]  o_imem_waddr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_start,
  input  logic               i_core_done,
  output logic               o_busy,
  output logic               o_finished,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_cycle_count,
  output logic [ADDR_W:0]    o_instr_count,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_END   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W:0]    r_instr_count;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               r_finished;
  logic               r_timeout;

  logic               w_accept;
  logic               w_at_top;
  logic               w_first_run;
  logic               w_done;
  logic               w_wd_hit;

  assign o_load_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_END);
  assign w_accept     = i_load_valid && o_load_ready;

  // Only LOAD continues a program; IDLE and END always begin at address 0.
  assign w_at_top     = (r_state == S_LOAD) && (r_instr_count[ADDR_W-1:0] == '1);

  // cycle_count is cleared in START and never wraps back to zero, so a zero
  // count in RUN identifies the first RUN cycle, whose done may be stale.
  assign w_first_run  = (r_cycle_count == '0);
  assign w_done       = i_core_done && !w_first_run;

`ifdef CORE_LAUNCHER_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  assign w_wd_hit = (r_cycle_count == TIMEOUT_C);
`else
  logic w_unused_timeout_param;
  assign w_unused_timeout_param = |TIMEOUT_CYCLES;
  assign w_wd_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_END: begin
        // A load beat wins over a simultaneous launch.
        if (w_accept)      w_next = i_load_last ? S_ARMED : S_LOAD;
        else if (i_launch) w_next = S_START;
      end
      S_LOAD: begin
        if (w_accept && (i_load_last || w_at_top)) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (i_launch) w_next = S_START;
      end
      S_START: w_next = S_RUN;
      S_RUN: begin
        if (w_done || w_wd_hit) w_next = S_END;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_instr_count <= '0;
      r_cycle_count <= '0;
      r_finished    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        if (r_state == S_LOAD) begin
          r_instr_count <= r_instr_count + 1'b1;
        end else begin
          r_instr_count <= (ADDR_W+1)'(1);
          r_finished    <= 1'b0;
          r_timeout     <= 1'b0;
        end
      end

      if (r_state == S_START) begin
        r_cycle_count <= '0;
        r_finished    <= 1'b0;
        r_timeout     <= 1'b0;
      end

      if (r_state == S_RUN) begin
        // done takes priority over the watchdog when both land together;
        // the count freezes on the terminating edge.
        if (w_done)                   r_finished    <= 1'b1;
        else if (w_wd_hit)            r_timeout     <= 1'b1;
        else if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
      end
    end
  end

  assign o_imem_wen    = w_accept;
  assign o_imem_waddr  = (r_state == S_LOAD) ? r_instr_count[ADDR_W-1:0] : '0;
  assign o_imem_wdata  = i_load_data;
  assign o_start       = (r_state == S_START);
  assign o_busy        = (r_state != S_IDLE);
  assign o_finished    = r_finished;
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;
  assign o_instr_count = r_instr_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_core_launcher.sv
// Testbench for core_launcher: directed vectors, write-port scoreboard,
// start-pulse monitor and status checks.
module tb_core_launcher;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;
  localparam int TMO     = 20;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;

  logic               clk;
  logic               reset;
  logic               load_valid;
  logic               load_ready;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               launch;
  logic               imem_wen;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               start;
  logic               core_done;
  logic               busy;
  logic               finished;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_count;
  logic [ADDR_W:0]    instr_count;
  logic [2:0]         state;

  core_launcher #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_load_valid(load_valid), .o_load_ready(load_ready),
    .i_load_data(load_data), .i_load_last(load_last),
    .i_launch(launch),
    .o_imem_wen(imem_wen), .o_imem_waddr(imem_waddr), .o_imem_wdata(imem_wdata),
    .o_start(start), .i_core_done(core_done),
    .o_busy(busy), .o_finished(finished), .o_timeout(timeout),
    .o_cycle_count(cycle_count), .o_instr_count(instr_count),
    .o_state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int starts_seen = 0;
  int exp_starts  = 0;
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Write-port monitor: every memory write must match the next expected one.
  always @(negedge clk) begin
    if (!reset && imem_wen) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL imem_write: unexpected write addr %0d data 0x%0h", imem_waddr, imem_wdata);
      end else begin
        logic [ADDR_W+INSTR_W-1:0] e;
        e = exp_q.pop_front();
        if ({imem_waddr, imem_wdata} != e) begin
          n_err++;
          $display("FAIL imem_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   imem_waddr, imem_wdata, e[ADDR_W+INSTR_W-1:INSTR_W], e[INSTR_W-1:0]);
        end
      end
    end
    if (start) starts_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [INSTR_W-1:0] d);
    exp_q.push_back({ADDR_W'(addr), d});
  endtask

  task automatic drive_word(input int addr, input logic [INSTR_W-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    push_wr(addr, d);
    tick();
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0;
    load_last  = 1'b0;
    launch     = 1'b0;
    core_done  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       state, ST_IDLE);
    check({tag, "_load_ready"},  load_ready, 1);
    check({tag, "_imem_wen"},    imem_wen, 0);
    check({tag, "_imem_waddr"},  imem_waddr, 0);
    check({tag, "_start"},       start, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_finished"},    finished, 0);
    check({tag, "_timeout"},     timeout, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_instr_count"}, instr_count, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    load_data = '0;
    idle_inputs();
    repeat (3) tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Three-word program, last on the third word.
    drive_word(0, 9'h1A3, 1'b0);
    drive_word(1, 9'h0F0, 1'b0);
    drive_word(2, 9'h000, 1'b1);
    idle_inputs();
    check("load3_instr_count", instr_count, 3);
    check("load3_state",       state, ST_ARMED);
    check("load3_load_ready",  load_ready, 0);
    check("load3_busy",        busy, 1);

    // Launch, done raised once 10 RUN cycles have elapsed.
    launch = 1'b1; exp_starts++;
    tick();
    launch = 1'b0;
    check("run1_start_pulse", start, 1);
    check("run1_state_start", state, ST_START);
    tick();
    check("run1_start_low",   start, 0);
    check("run1_state_run",   state, ST_RUN);
    check("run1_count0",      cycle_count, 0);
    repeat (10) tick();
    check("run1_count10",     cycle_count, 10);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("run1_finished",    finished, 1);
    check("run1_cycle_count", cycle_count, 10);
    check("run1_state_end",   state, ST_END);
    check("run1_busy",        busy, 1);
    tick();
    check("run1_finished_hold", finished, 1);
    check("run1_count_hold",    cycle_count, 10);

    // Rerun from END with a stale done held high from the START cycle on.
    launch = 1'b1; core_done = 1'b1; exp_starts++;
    tick();
    launch = 1'b0;
    check("rerun_start_pulse", start, 1);
    tick();
    check("rerun_finished_clr", finished, 0);
    check("rerun_state_run",    state, ST_RUN);
    tick();
    check("rerun_stale_ignored", state, ST_RUN);
    check("rerun_count1",        cycle_count, 1);
    tick();
    core_done = 1'b0;
    check("rerun_state_end",   state, ST_END);
    check("rerun_finished",    finished, 1);
    check("rerun_count_frz",   cycle_count, 1);

    // 256 words with no last: forced ARMED after address 255; launch mid-load ignored.
    for (int i = 0; i < 256; i++) begin
      launch = (i == 100);
      drive_word(i, INSTR_W'((i * 37 + 5) & 9'h1FF), 1'b0);
      if (i == 0) begin
        check("stream_flags_clr", finished, 0);
        check("stream_state_load", state, ST_LOAD);
      end
      if (i == 100) check("stream_launch_ignored", state, ST_LOAD);
    end
    launch    = 1'b0;
    load_data = 9'h1FF;  // 257th word stays offered
    check("stream_state_armed", state, ST_ARMED);
    check("stream_instr_count", instr_count, 256);
    check("stream_load_ready",  load_ready, 0);
    repeat (3) tick();
    check("stall_load_ready", load_ready, 0);
    check("stall_state",      state, ST_ARMED);
    idle_inputs();

    // Reset 5 cycles into RUN, then relaunch from IDLE with the old program.
    launch = 1'b1; exp_starts++;
    tick();
    launch = 1'b0;
    tick();
    repeat (5) tick();
    check("midrun_state", state, ST_RUN);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrst");
    launch = 1'b1; exp_starts++;
    tick();
    launch = 1'b0;
    check("relaunch_start", start, 1);
    tick();
    check("relaunch_start_low", start, 0);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("relaunch_finished", finished, 1);
    check("relaunch_count",    cycle_count, 1);

    // load_valid and launch together in IDLE: load wins, no start.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    launch = 1'b1;
    drive_word(0, 9'h055, 1'b1);
    idle_inputs();
    check("ldlaunch_no_start", start, 0);
    check("ldlaunch_state",    state, ST_ARMED);
    check("ldlaunch_instr",    instr_count, 1);
    tick();
    check("ldlaunch_no_start2", start, 0);

    // Watchdog / indefinite wait with done held low.
    launch = 1'b1; exp_starts++;
    tick();
    launch = 1'b0;
    tick();
`ifdef CORE_LAUNCHER_WATCHDOG_EN
    begin
      int budget;
      budget = 0;
      while (state != ST_END && budget < 100) begin
        tick();
        budget++;
      end
      check("wd_reached_end", state, ST_END);
      check("wd_timeout",     timeout, 1);
      check("wd_finished",    finished, 0);
      check("wd_cycle_count", cycle_count, TMO);
    end
`else
    repeat (1000) tick();
    check("nowd_state_run", state, ST_RUN);
    check("nowd_timeout",   timeout, 0);
    check("nowd_count",     cycle_count, 1000);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("nowd_finished",  finished, 1);
`endif

    tick();
    check("start_pulse_total", starts_seen, exp_starts);
    check("exp_q_drained",     exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_launcher.md
# core_launcher

Host-side initiator for the core's start/done handshake. Streams 9-bit machine words into instruction memory over a valid/ready port, then pulses `start` to the core, waits for `done`, and reports run length and outcome. Sits between the testbench or host interface and the core top level, and owns the instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory address width. Matches the 8-bit PC.
- `INSTR_W`, 9: machine-word width.
- `CNT_W`, 16: width of the run-cycle counter.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in RUN. Used only when the watchdog is compiled in.

Ports:
- `clk`, in, 1: the block's single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `load_valid`, in, 1: a load word is offered.
- `load_ready`, out, 1: the block accepts a word this cycle.
- `load_data`, in, INSTR_W: machine word.
- `load_last`, in, 1: marks the final word of the program.
- `launch`, in, 1: request a run of the loaded program.
- `imem_wen`, out, 1: instruction-memory write enable.
- `imem_waddr`, out, ADDR_W: write address.
- `imem_wdata`, out, INSTR_W: write data.
- `start`, out, 1: one-cycle start pulse to the core.
- `core_done`, in, 1: the core's `done` output.
- `busy`, out, 1: high in every state except IDLE.
- `finished`, out, 1: the run ended with `core_done`.
- `timeout`, out, 1: the run ended on the watchdog.
- `cycle_count`, out, CNT_W: cycles spent in RUN.
- `instr_count`, out, ADDR_W+1: number of words loaded.

## Operation
States: IDLE, LOAD, ARMED, START, RUN, END.
- **IDLE**
  - `load_ready`=1.
  - An accepted word (`load_valid`&&`load_ready`) writes address 0, sets `instr_count`=1, and moves to LOAD. If `load_last` is also set, it moves to ARMED instead.
  - `launch` alone moves to START and reuses the existing program.
  - If `load_valid` and `launch` arrive together, the load wins and `launch` is dropped.
- **LOAD**
  - `load_ready`=1.
  - Each accepted word writes at `instr_count` and increments it.
  - `load_last` moves to ARMED.
  - Writing address 2^ADDR_W−1 forces ARMED, as if `load_last` were set.
  - `launch` is ignored in this state.
- **ARMED**
  - `load_ready`=0.
  - `launch` moves to START.
- **START**
  - `start`=1 for exactly one cycle.
  - Clears `cycle_count`, `finished` and `timeout`.
  - Always goes to RUN.
- **RUN**
  - `cycle_count` increments each cycle and saturates at all-ones.
  - `core_done`=1 sets `finished` and moves to END.
  - `core_done` sampled in the first RUN cycle is ignored, because it can be stale from the previous run.
- **END**
  - `finished` or `timeout` holds.
  - `launch` reruns the program (goes to START).
  - An accepted `load_valid` starts a new load at address 0. Both status flags clear on that first load beat.
- Memory write signals:
  - `imem_wen` is combinational: `load_valid`&&`load_ready`.
  - `imem_waddr` and `imem_wdata` are driven from the current count and `load_data`.

## Timing
- Reset values:
  - State IDLE.
  - `load_ready`=1.
  - `imem_wen`=0, `imem_waddr`=0.
  - `start`=0, `busy`=0, `finished`=0, `timeout`=0.
  - `cycle_count`=0, `instr_count`=0.
- Load throughput is one word per cycle with no bubbles.
- `launch` sampled at edge N (in ARMED or END) gives `start`=1 during cycle N+1. RUN begins at N+2.
- `core_done` high at edge M in RUN (not the first RUN cycle) gives `finished`=1 from M+1. `cycle_count` freezes at the value it held at M.
- Reset asserted mid-load or mid-run returns to IDLE on the next edge with all outputs at reset values.
  - The instruction memory contents are not cleared.
  - `start` never glitches during reset.
- `load_valid` while `load_ready`=0 is not consumed. The source must hold the word.

## Configuration
- `CORE_LAUNCHER_WATCHDOG_EN` defined:
  - In RUN, `cycle_count` reaching TIMEOUT_CYCLES without `core_done` sets `timeout`=1 and moves to END.
  - If `core_done` and the limit occur in the same cycle, `core_done` wins: `finished`=1, `timeout`=0.
- Undefined:
  - RUN waits indefinitely.
  - `timeout` is tied to 0.
  - The limit comparator is not built.

## Test plan
- Load 3 words (0x1A3, 0x0F0, 0x000, last on the third) → `imem_wen` pulses at addresses 0, 1, 2. `instr_count`=3. State ARMED, `load_ready`=0.
- ARMED, `launch`, core raises `core_done` 10 RUN cycles later → `start` high for exactly 1 cycle. `finished`=1, `cycle_count`=10, `busy` stays 1 in END.
- Stream 256 words with no `load_last` → last write at address 255, forced ARMED, `instr_count`=256. A 257th word is stalled with `load_ready`=0.
- `load_valid` and `launch` together in IDLE → word written at address 0, no `start` pulse.
- With `CORE_LAUNCHER_WATCHDOG_EN`, TIMEOUT_CYCLES=20, and `core_done` held low → `timeout`=1, `finished`=0, `cycle_count`=20. Without the macro, the state is still RUN after 1000 cycles.
- `reset` asserted 5 cycles into RUN, then released → IDLE with all outputs at reset values. A following `launch` produces one `start` pulse using the previously loaded words.
